// File: rtl/regfile_alu_datapath.sv
// rtl/regfile_alu_datapath.sv - 8x16 register file feeding a combinational ALU
//
// Optional feature macro: WRITE_BYPASS_EN
//   defined   : a read whose address matches a pending write returns write_data
//               combinationally (write-through forwarding to data_a/data_b and the ALU).
//   undefined : reads always return the stored contents; new values appear after the edge.

module regfile_alu_datapath #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic              write_enable,
  input  logic [DATA_W-1:0] write_data,
  input  logic [3:0]        opcode,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero
);

  localparam int DEPTH = 2 ** ADDR_W;

  // ALU operation encodings (instruction[15:12]); every other code yields zero
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1001;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] stored_a;
  logic [DATA_W-1:0] stored_b;
  logic [3:0]        shamt;

  // Register storage: async clear of every entry, single write port at address_a.
  // The write is qualified only by write_enable, so X on an address or opcode
  // cannot disturb stored state while write_enable is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_enable) begin
      regs[address_a] <= write_data;
    end
  end

  assign stored_a = regs[address_a];
  assign stored_b = regs[address_b];

`ifdef WRITE_BYPASS_EN
  // Read ports with forwarding: a pending write to the addressed entry is seen
  // immediately. Port A always matches the write address by construction.
  always_comb begin
    data_a = stored_a;
    data_b = stored_b;
    if (write_enable && !rst) begin
      data_a = write_data;
      if (address_b == address_a) begin
        data_b = write_data;
      end
    end
  end
`else
  // Read ports: plain asynchronous reads of the stored contents.
  always_comb begin
    data_a = stored_a;
    data_b = stored_b;
  end
`endif

  // Only the low four bits of operand B select the shift distance
  assign shamt = data_b[3:0];

  // Stateless ALU: unsigned arithmetic wrapping at DATA_W bits, no carry out
  always_comb begin
    alu_result = '0;
    case (opcode)
      OP_ADD:  alu_result = data_a + data_b;
      OP_SUB:  alu_result = data_a - data_b;
      OP_AND:  alu_result = data_a & data_b;
      OP_OR:   alu_result = data_a | data_b;
      OP_XOR:  alu_result = data_a ^ data_b;
      OP_SHL:  alu_result = data_a << shamt;
      OP_SHR:  alu_result = data_a >> shamt;
      default: alu_result = '0;
    endcase
  end

  // Zero flag is produced for every opcode; the processor decides when to latch it
  assign zero = (alu_result == '0);

endmodule

// File: tb/tb_regfile_alu_datapath.sv
// tb/tb_regfile_alu_datapath.sv - self-checking bench for regfile_alu_datapath

module tb_regfile_alu_datapath;

  logic        clk;
  logic        rst;
  logic [2:0]  address_a;
  logic [2:0]  address_b;
  logic        write_enable;
  logic [15:0] write_data;
  logic [3:0]  opcode;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic [15:0] alu_result;
  logic        zero;

  int total;
  int bad;
  int model [8];

  regfile_alu_datapath #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .address_a    (address_a),
    .address_b    (address_b),
    .write_enable (write_enable),
    .write_data   (write_data),
    .opcode       (opcode),
    .data_a       (data_a),
    .data_b       (data_b),
    .alu_result   (alu_result),
    .zero         (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU from the operation table, using integer arithmetic
  function automatic logic [15:0] alu_ref(input int op, input int a, input int b);
    longint r;
    longint s;
    s = longint'(b % 16);
    case (op)
      2:       r = (a + b) % 65536;
      3:       r = (a - b + 65536) % 65536;
      4:       r = a & b;
      5:       r = a | b;
      6:       r = a ^ b;
      7:       r = (longint'(a) * (64'd1 << s)) % 65536;
      9:       r = longint'(a) / (64'd1 << s);
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  task automatic write_reg(input int addr, input int val);
    @(negedge clk);
    address_a    = 3'(addr);
    write_data   = 16'(val);
    write_enable = 1'b1;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    model[addr]  = val;
  endtask

  task automatic read_check(input string tag, input int aa, input int ab, input int op);
    logic [15:0] exp;
    @(negedge clk);
    address_a    = 3'(aa);
    address_b    = 3'(ab);
    opcode       = 4'(op);
    write_enable = 1'b0;
    #1;
    exp = alu_ref(op, model[aa], model[ab]);
    check({tag, ".a"}, 32'(data_a), 32'(model[aa]));
    check({tag, ".b"}, 32'(data_b), 32'(model[ab]));
    check({tag, ".alu"}, 32'(alu_result), 32'(exp));
    check({tag, ".zero"}, 32'(zero), 32'(exp == 16'h0));
  endtask

  task automatic expect_alu(input string tag, input int aa, input int ab, input int op,
                            input logic [15:0] exp_res, input logic exp_zero);
    @(negedge clk);
    address_a = 3'(aa);
    address_b = 3'(ab);
    opcode    = 4'(op);
    #1;
    check({tag, ".alu"}, 32'(alu_result), 32'(exp_res));
    check({tag, ".zero"}, 32'(zero), 32'(exp_zero));
  endtask

  initial begin
    int wa, ra, rb, op, v;
    logic [15:0] old7;
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    address_a    = '0;
    address_b    = '0;
    write_enable = 1'b0;
    write_data   = '0;
    opcode       = '0;
    for (int i = 0; i < 8; i++) model[i] = 0;

    // Reset state
    #12;
    check("rst.data_a", 32'(data_a), 32'h0);
    check("rst.data_b", 32'(data_b), 32'h0);
    check("rst.zero", 32'(zero), 32'h1);

    // Writes while rst is high are ignored
    @(negedge clk);
    address_a = 3'd2; write_data = 16'hAAAA; write_enable = 1'b1;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    check("rst.nowrite", 32'(data_a), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Preload 0xFFFF everywhere, then assert rst mid-cycle
    for (int i = 0; i < 8; i++) write_reg(i, 16'hFFFF);
    read_check("preload", 3, 4, 3);
    @(negedge clk);
    address_a = 3'd5; address_b = 3'd6; opcode = 4'b0010;
    #2;
    rst = 1'b1;
    #1;
    check("midrst.data_a", 32'(data_a), 32'h0);
    check("midrst.data_b", 32'(data_b), 32'h0);
    check("midrst.zero", 32'(zero), 32'h1);
    for (int i = 0; i < 8; i++) model[i] = 0;
    @(negedge clk);
    rst = 1'b0;

    // Directed write/read and ALU cases
    write_reg(1, 16'h0005);
    write_reg(2, 16'h0003);
    expect_alu("add12", 1, 2, 4'b0010, 16'h0008, 1'b0);
    expect_alu("sub12", 1, 2, 4'b0011, 16'h0002, 1'b0);
    write_reg(3, 16'h1234);
    write_reg(4, 16'h1234);
    expect_alu("sub34", 3, 4, 4'b0011, 16'h0000, 1'b1);
    expect_alu("sub01", 0, 1, 4'b0011, 16'hFFFB, 1'b0);
    write_reg(5, 16'hFFFF);
    write_reg(6, 16'h0001);
    expect_alu("addwrap", 5, 6, 4'b0010, 16'h0000, 1'b1);
    expect_alu("shl61", 6, 1, 4'b0111, 16'h0020, 1'b0);
    expect_alu("undef", 1, 2, 4'b1111, 16'h0000, 1'b1);
    expect_alu("same", 1, 1, 4'b0010, 16'h000A, 1'b0);

    // Write gating: no write without write_enable
    @(negedge clk);
    address_a = 3'd1; write_data = 16'hBEEF; write_enable = 1'b0;
    @(posedge clk);
    #1;
    check("gate.r1", 32'(data_a), 32'h0005);

    // Same-cycle write and read of r7
    old7 = 16'(model[7]);
    @(negedge clk);
    address_a = 3'd7; address_b = 3'd7; write_data = 16'hBEEF; write_enable = 1'b1;
    #1;
`ifdef WRITE_BYPASS_EN
    check("samecyc.a", 32'(data_a), 32'hBEEF);
    check("samecyc.b", 32'(data_b), 32'hBEEF);
`else
    check("samecyc.a", 32'(data_a), 32'(old7));
    check("samecyc.b", 32'(data_b), 32'(old7));
`endif
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    model[7] = 16'hBEEF;
    check("after.r7", 32'(data_a), 32'hBEEF);

    // Randomized writes and reads against the array model
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        wa = int'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0:       v = 0;
          1:       v = 16'hFFFF;
          default: v = int'($urandom_range(0, 65535));
        endcase
        write_reg(wa, v);
      end
      ra = int'($urandom_range(0, 7));
      rb = int'($urandom_range(0, 7));
      op = int'($urandom_range(0, 15));
      read_check("rand", ra, rb, op);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
